ped_phase_scheduler: RTL
========================

Name: ped_phase_scheduler

Overview:
- Collects pedestrian push-button requests from four crosswalks and schedules on-demand walk phases into the intersection light sequencer.
- Requests an all-red window from the light sequencer with a req/gnt handshake, then drives per-crosswalk WALK and flashing DON'T-WALK outputs.
- Handles emergency preemption, enforces a minimum gap between walk phases, and latches a fault on safety violations.

Parameters:
- N_XWALK, 4, number of crosswalks; fixed at 4 in this revision.
- WALK_TIME, 15, cycles WALK is asserted; range 1..255.
- CLEAR_TIME, 5, cycles flashing DON'T-WALK is asserted; range 1..255.
- MIN_GAP, 20, cycles after a phase ends before the next phase_req may assert; range 0..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- btn  in  4  debounced, level-sampled push-buttons, one bit per crosswalk.
- emerg  in  1  emergency vehicle preemption.
- all_red  in  1  light sequencer status: 1 = every vehicle head is RED.
- phase_gnt  in  1  light sequencer grants the all-red window.
- phase_req  out  1  request / hold the all-red window.
- walk  out  4  WALK indication per crosswalk.
- flash_dw  out  4  flashing DON'T-WALK (clearance) per crosswalk.
- pending  out  4  latched outstanding requests.
- phase_done  out  1  single-cycle pulse at the end of every walk phase.
- aborted  out  1  qualifies phase_done: 1 = phase cut short by emerg.
- fault  out  1  sticky safety fault.

Behaviour:
- Reset (async): state IDLE, timer 0, serve_set 0. All outputs 0 (phase_req, walk, flash_dw, pending, phase_done, aborted, fault).
- pending[i] is set the cycle after btn[i] is sampled high. Exception: a press on a crosswalk already in serve_set is ignored during WALK and CLEAR.
- State machine: IDLE, REQ, WALK, CLEAR, GAP, FAULT. Single 8-bit timer, cleared on every state change.
- IDLE:
  - If pending != 0 and emerg = 0: go to REQ. phase_req asserts the next cycle (registered).
- REQ:
  - phase_req = 1.
  - If emerg = 1: drop phase_req, return to IDLE, pending kept.
  - Else if phase_gnt = 1 and all_red = 1 in the same cycle: serve_set <= pending, go to WALK.
  - phase_gnt without all_red is ignored; the block waits.
- WALK:
  - phase_req = 1, walk = serve_set, held for exactly WALK_TIME cycles, then go to CLEAR.
  - If emerg = 1: go to CLEAR immediately (next cycle) and set an internal abort flag.
- CLEAR:
  - phase_req = 1, flash_dw = serve_set, held for exactly CLEAR_TIME cycles.
  - emerg has no further effect.
  - On the last CLEAR cycle the following register for one cycle:
    - phase_done = 1 and aborted = abort flag.
    - If not aborted: pending <= (pending & ~serve_set) | new presses.
    - If aborted: pending is kept, so the served crosswalks are re-served later.
    - phase_req drops and the block goes to GAP.
- GAP:
  - All outputs idle for MIN_GAP cycles, then IDLE.
  - MIN_GAP = 0 goes straight to IDLE.
  - Presses are still latched during GAP.
- Safety fault:
  - Trigger: all_red = 0 in any WALK or CLEAR cycle.
  - Next cycle: walk and flash_dw = 0, phase_req = 0, fault = 1, state FAULT.
  - FAULT exits only via reset. pending keeps latching but is never served.
- walk and flash_dw are never nonzero in the same cycle. Both are always a subset of serve_set.
- Simultaneous emerg with phase_gnt + all_red in REQ: emerg wins, go to IDLE.
- Reset mid-phase: all outputs drop asynchronously; pending is lost.
- Latency: btn high at cycle k gives pending at k+1 and phase_req at k+2 (from IDLE, gap expired).

Test Plan:
- btn=4'b0010 one cycle, gnt and all_red at cycle 5 -> phase_req at cycle 2; walk=0010 for 15 cycles; flash_dw=0010 for 5 cycles; phase_done=1, aborted=0; pending=0; phase_req low for 20 cycles.
- btn=0001 then btn=1000 three cycles later, before gnt -> serve_set=1001; both walk together; pending=0 after phase_done.
- emerg at WALK cycle 7 -> walk drops the next cycle; flash_dw 5 cycles; phase_done with aborted=1; pending still 0100; re-request after the 20-cycle gap.
- gnt=1 with all_red=0 for 10 cycles, then all_red=1 -> no walk until the all_red cycle; WALK begins the next cycle.
- all_red falls during CLEAR -> flash_dw=0 and fault=1 the next cycle; no further phase_req until reset.
- btn on the served crosswalk during WALK, plus btn on another crosswalk in GAP -> the served press is ignored, the other is latched; after the gap, serve_set contains only the other crosswalk.

Source files
------------

// File: rtl/ped_phase_if.sv
// ped_phase_if: buttons, light-sequencer handshake and pedestrian indications
// shared between the scheduler (slave) and its environment (master).
interface ped_phase_if #(parameter int N = 4);
    logic [N-1:0] btn, walk, flash_dw, pending;
    logic emerg, all_red, phase_gnt, phase_req, phase_done, aborted, fault;
    modport master (
        output btn, emerg, all_red, phase_gnt,
        input  phase_req, walk, flash_dw, pending, phase_done, aborted, fault
    );
    modport slave (
        input  btn, emerg, all_red, phase_gnt,
        output phase_req, walk, flash_dw, pending, phase_done, aborted, fault
    );
endinterface

// File: rtl/ped_phase_scheduler.sv
// ped_phase_scheduler: latches crosswalk requests and runs WALK / flashing DON'T-WALK
// phases inside an all-red window, with emergency preemption, minimum gap and sticky fault.
module ped_phase_scheduler #(
    parameter int N_XWALK    = 4,
    parameter int WALK_TIME  = 15,
    parameter int CLEAR_TIME = 5,
    parameter int MIN_GAP    = 20
) (
    input logic        clk,
    input logic        reset,
    ped_phase_if.slave ped_if
);
    typedef enum logic [2:0] {IDLE, REQ, WALK, CLEAR, GAP, FAULT} state_t;
    localparam logic [7:0] WALK_LAST  = 8'(WALK_TIME - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_TIME - 1);
    localparam logic [7:0] GAP_LAST   = 8'(MIN_GAP - 1);
    state_t             state_q;
    logic [7:0]         timer_q;
    logic [N_XWALK-1:0] serve_q, pending_q, pending_d, walk_q, flash_q, press;
    logic               abort_q, req_q, done_q, aborted_q, fault_q;
    logic               in_phase, unsafe, clear_end;
    always_comb begin
        in_phase  = (state_q == WALK) || (state_q == CLEAR);
        unsafe    = in_phase && !ped_if.all_red;
        clear_end = (state_q == CLEAR) && (timer_q == CLEAR_LAST) && !unsafe;
        // re-presses on crosswalks being served are meaningless while they are served
        press     = in_phase ? ped_if.btn & ~serve_q : ped_if.btn;
        pending_d = ((clear_end && !abort_q) ? pending_q & ~serve_q : pending_q) | press;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            serve_q   <= '0;
            pending_q <= '0;
            walk_q    <= '0;
            flash_q   <= '0;
            abort_q   <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            timer_q   <= timer_q + 8'd1;
            if (unsafe) begin
                state_q <= FAULT;
                timer_q <= '0;
                req_q   <= 1'b0;
                walk_q  <= '0;
                flash_q <= '0;
                fault_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (|pending_q && !ped_if.emerg) begin
                        state_q <= REQ;
                        timer_q <= '0;
                        req_q   <= 1'b1;
                    end
                    REQ: if (ped_if.emerg) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        req_q   <= 1'b0;
                    end else if (ped_if.phase_gnt && ped_if.all_red) begin
                        state_q <= WALK;
                        timer_q <= '0;
                        serve_q <= pending_q;
                        walk_q  <= pending_q;
                        abort_q <= 1'b0;
                    end
                    WALK: if (ped_if.emerg || timer_q == WALK_LAST) begin
                        state_q <= CLEAR;
                        timer_q <= '0;
                        walk_q  <= '0;
                        flash_q <= serve_q;
                        abort_q <= ped_if.emerg;
                    end
                    CLEAR: if (timer_q == CLEAR_LAST) begin
                        state_q   <= (MIN_GAP == 0) ? IDLE : GAP;
                        timer_q   <= '0;
                        flash_q   <= '0;
                        req_q     <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= abort_q;
                    end
                    GAP: if (timer_q == GAP_LAST) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
    assign ped_if.phase_req  = req_q;
    assign ped_if.walk       = walk_q;
    assign ped_if.flash_dw   = flash_q;
    assign ped_if.pending    = pending_q;
    assign ped_if.phase_done = done_q;
    assign ped_if.aborted    = aborted_q;
    assign ped_if.fault      = fault_q;
endmodule
